// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - control bus between the multi-cycle sequencer and the RV32I datapath
// The master drives the datapath strobes and reads the IR opcode and the condition flags.
interface multicycle_control_unit_if;
    logic [6:0] part_of_inst;
    logic       alu_bcond;
    logic       halt_cond;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_to_reg;
    logic       pc_to_reg;

    modport master (
        input  part_of_inst, alu_bcond, halt_cond,
        output pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
               alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, pc_to_reg
    );

    modport slave (
        output part_of_inst, alu_bcond, halt_cond,
        input  pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
               alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, pc_to_reg
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - IF/ID/EX/MEM/WB sequencer for the multi-cycle RV32I core
// Outputs are decoded combinationally from state, wait count, opcode and the condition inputs.
module multicycle_control_unit #(
    parameter int MEM_CYCLES = 1,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    multicycle_control_unit_if.master ctrl,
    output logic                     is_ecall,
    output logic                     halted,
    output logic                     illegal_inst,
    output logic [2:0]               state,
    output logic [CNT_WIDTH-1:0]     retired_count
);

    localparam int WCNT_W = (MEM_CYCLES > 1) ? $clog2(MEM_CYCLES) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_CYCLES - 1);

    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_ECALL     = 7'b1110011;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_e;

    state_e                 state_q, state_d;
    logic [WCNT_W-1:0]      wcnt_q, wcnt_d;
    logic [CNT_WIDTH-1:0]   retired_q, retired_d;

    logic       pc_write, i_or_d, mem_read, mem_write, ir_write, alu_src_a;
    logic       reg_write, mem_to_reg, pc_to_reg;
    logic [1:0] pc_source, alu_src_b, alu_op;
    logic       ecall_c, halted_c, illegal_c;

    logic [6:0] opc;
    logic       op_known, op_load, op_store, mem_last;

    assign opc      = ctrl.part_of_inst;
    assign op_load  = (opc == OP_LOAD);
    assign op_store = (opc == OP_STORE);
    assign mem_last = (wcnt_q == WCNT_LAST);
    assign op_known = (opc == OP_ARITH) || (opc == OP_ARITH_IMM) || op_load || op_store ||
                      (opc == OP_BRANCH) || (opc == OP_JAL) || (opc == OP_JALR);

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        pc_write   = 1'b0;
        pc_source  = 2'b00;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        pc_to_reg  = 1'b0;
        ecall_c    = 1'b0;
        halted_c   = 1'b0;
        illegal_c  = 1'b0;

        case (state_q)
            S_IF: begin
                mem_read = 1'b1;
                if (mem_last) begin
                    ir_write = 1'b1;
                    wcnt_d   = '0;
                    state_d  = S_ID;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            S_ID: begin
                // ALUOut captures PC+imm here so EX of a BRANCH/JAL can load it
                alu_src_b = 2'b10;
                if (opc == OP_ECALL) begin
                    ecall_c = 1'b1;
                    if (ctrl.halt_cond) begin
                        state_d = S_HALT;
                    end else begin
                        pc_write = 1'b1;
                        state_d  = S_IF;
                    end
                end else if (!op_known) begin
                    illegal_c = 1'b1;
                    pc_write  = 1'b1;
                    state_d   = S_IF;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                state_d = S_IF;
                case (opc)
                    OP_ARITH: begin
                        alu_src_a = 1'b1;
                        alu_op    = 2'b10;
                        state_d   = S_WB;
                    end
                    OP_ARITH_IMM: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b10;
                        alu_op    = 2'b10;
                        state_d   = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b10;
                        state_d   = S_MEM;
                    end
                    OP_BRANCH: begin
                        alu_src_a = 1'b1;
                        alu_op    = 2'b01;
                        pc_write  = 1'b1;
                        pc_source = ctrl.alu_bcond ? 2'b10 : 2'b00;
                    end
                    OP_JAL: begin
                        reg_write = 1'b1;
                        pc_to_reg = 1'b1;
                        pc_write  = 1'b1;
                        pc_source = 2'b10;
                    end
                    OP_JALR: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b10;
                        reg_write = 1'b1;
                        pc_to_reg = 1'b1;
                        pc_write  = 1'b1;
                        pc_source = 2'b01;
                    end
                    // Opcode changed under us after ID: retire as a NOP rather than stall
                    default: pc_write = 1'b1;
                endcase
            end
            S_MEM: begin
                i_or_d    = 1'b1;
                mem_read  = op_load;
                mem_write = op_store;
                if (mem_last) begin
                    wcnt_d = '0;
                    if (op_store) begin
                        pc_write = 1'b1;
                        state_d  = S_IF;
                    end else begin
                        state_d = S_WB;
                    end
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = op_load;
                pc_write   = 1'b1;
                state_d    = S_IF;
            end
            S_HALT: halted_c = 1'b1;
            default: begin
                state_d = S_IF;
                wcnt_d  = '0;
            end
        endcase

        retired_d = pc_write ? (retired_q + CNT_WIDTH'(1)) : retired_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IF;
            wcnt_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            retired_q <= retired_d;
        end
    end

    assign ctrl.pc_write   = pc_write;
    assign ctrl.pc_source  = pc_source;
    assign ctrl.i_or_d     = i_or_d;
    assign ctrl.mem_read   = mem_read;
    assign ctrl.mem_write  = mem_write;
    assign ctrl.ir_write   = ir_write;
    assign ctrl.alu_src_a  = alu_src_a;
    assign ctrl.alu_src_b  = alu_src_b;
    assign ctrl.alu_op     = alu_op;
    assign ctrl.reg_write  = reg_write;
    assign ctrl.mem_to_reg = mem_to_reg;
    assign ctrl.pc_to_reg  = pc_to_reg;

    assign is_ecall      = ecall_c;
    assign halted        = halted_c;
    assign illegal_inst  = illegal_c;
    assign state         = state_q;
    assign retired_count = retired_q;

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Sequencing control unit for the multi-cycle RV32I core, the successor to the single-cycle decoder. Steps each instruction through IF/ID/EX/MEM/WB with per-opcode early exit. Waits a parametrised number of cycles on each memory access. Drives every datapath strobe, handles ECALL halt, and counts retired instructions. Sits between the instruction register (opcode input) and the shared-memory multi-cycle datapath.

## Interface
- MEM_CYCLES, 1, cycles each memory access occupies (≥1); applies to IF and MEM
- CNT_WIDTH, 32, width of retired-instruction counter
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low (asserted when 0)
- part_of_inst  in  7  opcode field of the IR; valid from ID onward; `opcodes.v` macros
- alu_bcond  in  1  branch condition from ALU, valid in EX of a BRANCH
- halt_cond  in  1  datapath: x17 == 10, sampled in ID of ECALL
- pc_write, pc_source[1:0]  out  1, 2  PC load enable; source 00 = PC+4 adder, 01 = ALU result, 10 = ALUOut
- i_or_d, mem_read, mem_write, ir_write  out  1 each  address select (0 = PC, 1 = ALUOut), memory strobes, IR load
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = 4, 10 = immediate
- alu_op  out  2  00 = ADD, 01 = branch compare, 10 = funct-decoded
- reg_write, mem_to_reg, pc_to_reg  out  1 each  register write, write-back source selects
- is_ecall, halted, illegal_inst  out  1 each  status
- state  out  3  IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5
- retired_count  out  CNT_WIDTH  instructions retired

## Operation
- Registered: state, wait counter `wcnt` (covers 0..MEM_CYCLES-1), retired_count. All outputs are combinational from state, wcnt, opcode, alu_bcond and halt_cond. Any output not listed below is 0.
- IF: i_or_d=0, mem_read=1.
  - While wcnt < MEM_CYCLES-1: increment wcnt, stay in IF.
  - On the final cycle: ir_write=1, wcnt←0, go to ID.
- ID: alu_src_a=0, alu_src_b=10, alu_op=00. ALUOut latches PC+imm.
  - ECALL: is_ecall=1. If halt_cond=1, go to HALT. Else pc_write=1, pc_source=00, go to IF.
  - Unrecognised opcode: illegal_inst=1, pc_write=1, pc_source=00, go to IF (treated as NOP).
  - All other opcodes go to EX.
- EX:
  - ARITHMETIC: src_a=1, src_b=00, op=10; go to WB.
  - ARITHMETIC_IMM: src_a=1, src_b=10, op=10; go to WB.
  - LOAD/STORE: src_a=1, src_b=10, op=00; go to MEM.
  - BRANCH: src_a=1, src_b=00, op=01, pc_write=1. pc_source=10 if alu_bcond else 00. Go to IF.
  - JAL: reg_write=1, pc_to_reg=1, pc_write=1, pc_source=10; go to IF.
  - JALR: src_a=1, src_b=10, op=00, reg_write=1, pc_to_reg=1, pc_write=1, pc_source=01 (the datapath clears bit 0); go to IF.
- MEM: i_or_d=1. mem_read=1 for LOAD; mem_write=1 for STORE, held for every MEM cycle.
  - Same wcnt scheme as IF.
  - On the final cycle, STORE: pc_write=1, pc_source=00, go to IF.
  - On the final cycle, LOAD: go to WB.
- WB: reg_write=1, mem_to_reg = (opcode==LOAD), pc_write=1, pc_source=00; go to IF.
- HALT: halted=1, all strobes 0; held until reset.
- retired_count increments by 1 in every cycle where pc_write=1 and the clock edge is taken. It wraps modulo 2^CNT_WIDTH. The halting ECALL does not count.

## Timing
- Reset assertion: state←IF, wcnt←0, retired_count←0 immediately (asynchronous). While reset is held, outputs show IF values: mem_read=1, ir_write = (MEM_CYCLES==1), all else 0.
- Reset release: first fetch starts on the first rising edge after release. Reset mid-instruction discards it with no partial commit.
- Cycles per instruction, M = MEM_CYCLES:
  - BRANCH, JAL, JALR: M+2
  - ALU ops: M+3
  - STORE: 2M+2
  - LOAD: 2M+3
  - ECALL and illegal opcodes: M+1
- pc_write is asserted in exactly one cycle per retired instruction, always the last cycle before IF.
- wcnt is 0 on every entry to IF and MEM; it never exceeds MEM_CYCLES-1.

## Test plan
- MEM_CYCLES=1, reset low then high, ADDI then ADD: states 0,1,2,4 per instruction. The WB cycle shows reg_write=1, mem_to_reg=0, pc_write=1, pc_source=00. retired_count=2 after 8 cycles.
- MEM_CYCLES=3, LW: IF holds 3 cycles with ir_write only in the 3rd; MEM holds 3 cycles with i_or_d=1, mem_read=1; WB has mem_to_reg=1. Total 9 cycles.
- BRANCH with alu_bcond=1 then 0: EX shows pc_write=1 with pc_source=10, then 00. Each takes 3 cycles at M=1.
- JAL then JALR: EX shows pc_to_reg=1 and reg_write=1, with pc_source=10 (JAL) and 01 (JALR).
- ECALL with halt_cond=0 gives is_ecall=1, pc_write=1, return to IF. ECALL with halt_cond=1 enters HALT, halted=1, and retired_count is frozen for 20+ cycles.
- Reset pulled low during MEM of a SW at M=3: state=0 and retired_count=0 immediately, with no mem_write after reset. Also CNT_WIDTH=4 with 17 NOPs gives retired_count=1.
